// File: rtl/pc_gen_if.sv
// pc_gen_if: groups the fetch handshake, redirect/trap inputs, debug controls
// and status outputs of the pc_gen program-counter generator.
//   master : the pc_gen side (drives the o_* signals)
//   slave  : the fetch/control side (drives the i_* signals)

interface pc_gen_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) ();

    // Fetch handshake
    logic                 i_fetch_ready;
    logic [WIDTH-1:0]     o_pc;
    logic                 o_pc_valid;

    // Control-flow redirection
    logic                 i_redirect_valid;
    logic [WIDTH-1:0]     i_redirect_pc;
    logic                 i_trap_valid;
    logic [WIDTH-1:0]     i_trap_pc;

    // Debug / stall control
    logic                 i_halt;
    logic                 i_resume;

    // Status
    logic                 o_halted;
    logic                 o_misalign;
    logic [CNT_WIDTH-1:0] o_fetch_cnt;

    modport master (
        input  i_fetch_ready,
        input  i_redirect_valid,
        input  i_redirect_pc,
        input  i_trap_valid,
        input  i_trap_pc,
        input  i_halt,
        input  i_resume,
        output o_pc,
        output o_pc_valid,
        output o_halted,
        output o_misalign,
        output o_fetch_cnt
    );

    modport slave (
        output i_fetch_ready,
        output i_redirect_valid,
        output i_redirect_pc,
        output i_trap_valid,
        output i_trap_pc,
        output i_halt,
        output i_resume,
        input  o_pc,
        input  o_pc_valid,
        input  o_halted,
        input  o_misalign,
        input  o_fetch_cnt
    );

endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the RV32I fetch stage.
//
// Holds the fetch address and offers it over a valid/ready handshake. The PC
// advances by INSTR_BYTES on each accepted fetch and can be redirected by a
// branch/jump or a trap (trap > redirect > sequential). HALT/resume give debug
// and stall control; a counter tracks accepted fetches.
//
// States: BOOT (one invalid cycle after reset), RUN (o_pc_valid=1),
//         HALT (o_pc_valid=0, o_halted=1).
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : misaligned redirect targets are rejected and o_misalign pulses.
//   undefined : redirect targets have their low ALIGN_BITS cleared,
//               o_misalign stays 0.
//
// All outputs are registered; reset (rst) is asynchronous and active-low.

module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter int               INSTR_BYTES  = 4,
    parameter int               CNT_WIDTH    = 16
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    localparam int               ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [WIDTH-1:0] LOW_MASK   = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Clear the sub-instruction address bits.
    function automatic logic [WIDTH-1:0] align_pc(input logic [WIDTH-1:0] pc);
        return pc & ~LOW_MASK;
    endfunction

`ifdef PC_ALIGN_CHECK_EN
    // True when the address is not on an instruction boundary.
    function automatic logic is_misaligned(input logic [WIDTH-1:0] pc);
        return |(pc & LOW_MASK);
    endfunction
`endif

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 boot_arm_r;
    logic                 boot_arm_nxt_s;

    logic [WIDTH-1:0]     pc_r;
    logic [WIDTH-1:0]     pc_nxt_s;
    logic                 pc_valid_r;
    logic                 halted_r;
    logic                 misalign_r;
    logic                 misalign_nxt_s;
    logic [CNT_WIDTH-1:0] fetch_cnt_r;

    logic                 active_s;
    logic                 accept_s;
    logic                 trap_s;
    logic                 redir_req_s;
    logic                 redir_take_s;
    logic                 redir_bad_s;
    logic [WIDTH-1:0]     redir_target_s;

    // Redirects and traps only take effect once out of BOOT; the valid flag
    // is only ever set in RUN, so accept needs no extra state qualification.
    assign active_s    = (state_r != ST_BOOT);
    assign accept_s    = pc_valid_r & bus.i_fetch_ready;
    assign trap_s      = bus.i_trap_valid & active_s;
    assign redir_req_s = bus.i_redirect_valid & active_s;

    // Qualify the redirect request and form its target address.
    always_comb begin
        redir_take_s   = 1'b0;
        redir_bad_s    = 1'b0;
        redir_target_s = align_pc(bus.i_redirect_pc);
`ifdef PC_ALIGN_CHECK_EN
        redir_target_s = bus.i_redirect_pc;
        if (redir_req_s && is_misaligned(bus.i_redirect_pc)) begin
            redir_bad_s = 1'b1;
        end else begin
            redir_take_s = redir_req_s;
        end
`else
        redir_take_s = redir_req_s;
`endif
    end

    // Next-PC selection: trap beats redirect beats sequential advance.
    always_comb begin
        pc_nxt_s = pc_r;
        if (trap_s) begin
            pc_nxt_s = align_pc(bus.i_trap_pc);
        end else if (redir_take_s) begin
            pc_nxt_s = redir_target_s;
        end else if (accept_s) begin
            pc_nxt_s = pc_r + PC_STEP;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // A rejected redirect is reported unless a trap overrides it anyway.
    always_comb begin
        misalign_nxt_s = 1'b0;
        if (redir_bad_s && !trap_s) begin
            misalign_nxt_s = 1'b1;
        end else begin
            misalign_nxt_s = 1'b0;
        end
    end

    // Next-state logic. BOOT spends the first edge after reset arming,
    // so o_pc_valid rises on the second edge. Halt beats resume; a trap
    // always lands in RUN.
    always_comb begin
        state_nxt_s    = state_r;
        boot_arm_nxt_s = boot_arm_r;
        case (state_r)
            ST_BOOT: begin
                if (boot_arm_r) begin
                    state_nxt_s    = ST_RUN;
                    boot_arm_nxt_s = 1'b0;
                end else begin
                    boot_arm_nxt_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (trap_s) begin
                    state_nxt_s = ST_RUN;
                end else if (bus.i_halt) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (trap_s) begin
                    state_nxt_s = ST_RUN;
                end else if (bus.i_halt) begin
                    state_nxt_s = ST_HALT;
                end else if (bus.i_resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s    = ST_BOOT;
                boot_arm_nxt_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_BOOT;
            boot_arm_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            boot_arm_r <= boot_arm_nxt_s;
        end
    end

    // PC and accepted-fetch counter (counter wraps naturally).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r        <= RESET_VECTOR;
            fetch_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            pc_r <= pc_nxt_s;
            if (accept_s) begin
                fetch_cnt_r <= fetch_cnt_r + CNT_WIDTH'(1'b1);
            end
        end
    end

    // Status flags registered from the next state so they line up with o_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_valid_r <= 1'b0;
            halted_r   <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            pc_valid_r <= (state_nxt_s == ST_RUN);
            halted_r   <= (state_nxt_s == ST_HALT);
            misalign_r <= misalign_nxt_s;
        end
    end

    assign bus.o_pc        = pc_r;
    assign bus.o_pc_valid  = pc_valid_r;
    assign bus.o_halted    = halted_r;
    assign bus.o_misalign  = misalign_r;
    assign bus.o_fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven self-checking bench for pc_gen.
// Each vector's expected outputs are queued when it is driven and popped and
// compared one edge later. Extra hand sequences cover counter wrap and
// asynchronous reset. Expectations follow the PC_ALIGN_CHECK_EN setting.

module tb_pc_gen;

    localparam int W  = 32;
    localparam int CW = 16;

    typedef struct {
        logic          ready;
        logic          rv;
        logic [W-1:0]  rpc;
        logic          tv;
        logic [W-1:0]  tpc;
        logic          halt;
        logic          resume;
        logic [W-1:0]  epc;
        logic          ev;
        logic          eh;
        logic          em;
        logic [CW-1:0] ecnt;
    } vec_t;

    typedef struct {
        logic [W-1:0]  pc;
        logic          valid;
        logic          halted;
        logic          misalign;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    vec_t vecs[28];

    pc_gen_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    pc_gen #(
        .WIDTH(W),
        .RESET_VECTOR(32'h0000_0000),
        .INSTR_BYTES(4),
        .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic ready, input logic rv, input logic [W-1:0] rpc,
                                input logic tv, input logic [W-1:0] tpc,
                                input logic halt, input logic resume,
                                input logic [W-1:0] epc, input logic ev, input logic eh,
                                input logic em, input logic [CW-1:0] ecnt);
        vec_t v;
        v.ready = ready; v.rv = rv; v.rpc = rpc; v.tv = tv; v.tpc = tpc;
        v.halt = halt; v.resume = resume;
        v.epc = epc; v.ev = ev; v.eh = eh; v.em = em; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_fetch_ready    = v.ready;
        bus.i_redirect_valid = v.rv;
        bus.i_redirect_pc    = v.rpc;
        bus.i_trap_valid     = v.tv;
        bus.i_trap_pc        = v.tpc;
        bus.i_halt           = v.halt;
        bus.i_resume         = v.resume;
    endtask

    // Drive one vector, queue its expectation, clock once, pop and compare.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        drive(v);
        e.pc = v.epc; e.valid = v.ev; e.halted = v.eh; e.misalign = v.em; e.cnt = v.ecnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".pc"},       bus.o_pc, e.pc);
            chk({tag, ".valid"},    W'(bus.o_pc_valid), W'(e.valid));
            chk({tag, ".halted"},   W'(bus.o_halted), W'(e.halted));
            chk({tag, ".misalign"}, W'(bus.o_misalign), W'(e.misalign));
            chk({tag, ".cnt"},      W'(bus.o_fetch_cnt), W'(e.cnt));
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".pc"},       bus.o_pc, 32'h0000_0000);
        chk({tag, ".valid"},    W'(bus.o_pc_valid), 32'd0);
        chk({tag, ".halted"},   W'(bus.o_halted), 32'd0);
        chk({tag, ".misalign"}, W'(bus.o_misalign), 32'd0);
        chk({tag, ".cnt"},      W'(bus.o_fetch_cnt), 32'd0);
    endtask

    initial begin
        logic [W-1:0] base_pc;
        vec_t idle;
        checks = 0;
        errors = 0;

        // ready rv rpc tv tpc halt resume | pc valid halted misalign cnt
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 16'd0);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h4,   1'b1, 1'b0, 1'b0, 16'd1);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h8,   1'b1, 1'b0, 1'b0, 16'd2);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'hC,   1'b1, 1'b0, 1'b0, 16'd3);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 1'b0, 16'd4);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 1'b0, 16'd4);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 1'b0, 16'd4);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 1'b0, 16'd4);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h14,  1'b1, 1'b0, 1'b0, 16'd5);
        vecs[10] = mk(1'b1, 1'b1, 32'h80,    1'b1, 32'h200, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 16'd6);
        vecs[11] = mk(1'b0, 1'b1, 32'h20,    1'b0, 32'h0,   1'b0, 1'b0, 32'h20,  1'b1, 1'b0, 1'b0, 16'd6);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 1'b0, 32'h24,  1'b0, 1'b1, 1'b0, 16'd7);
        vecs[13] = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h24,  1'b0, 1'b1, 1'b0, 16'd7);
        vecs[14] = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 1'b1, 32'h24,  1'b0, 1'b1, 1'b0, 16'd7);
        vecs[15] = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b1, 32'h24,  1'b1, 1'b0, 1'b0, 16'd7);
        vecs[16] = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h28,  1'b1, 1'b0, 1'b0, 16'd8);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 1'b0, 32'h28,  1'b0, 1'b1, 1'b0, 16'd8);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,     1'b1, 32'h302, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0, 16'd8);
`ifdef PC_ALIGN_CHECK_EN
        vecs[19] = mk(1'b0, 1'b1, 32'h102,   1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b1, 16'd8);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0, 16'd8);
`else
        vecs[19] = mk(1'b0, 1'b1, 32'h102,   1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 16'd8);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 16'd8);
`endif
        vecs[21] = mk(1'b0, 1'b1, 32'h103,   1'b1, 32'h400, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0, 1'b0, 16'd8);
        vecs[22] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 16'd8);
        vecs[23] = mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 16'd9);
        vecs[24] = mk(1'b1, 1'b1, 32'h40,    1'b0, 32'h0,   1'b1, 1'b0, 32'h40,  1'b0, 1'b1, 1'b0, 16'd10);
        vecs[25] = mk(1'b0, 1'b0, 32'h0,     1'b1, 32'h80,  1'b0, 1'b0, 32'h80,  1'b1, 1'b0, 1'b0, 16'd10);
`ifdef PC_ALIGN_CHECK_EN
        vecs[26] = mk(1'b1, 1'b1, 32'h106,   1'b0, 32'h0,   1'b0, 1'b0, 32'h84,  1'b1, 1'b0, 1'b1, 16'd11);
        vecs[27] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h84,  1'b1, 1'b0, 1'b0, 16'd11);
`else
        vecs[26] = mk(1'b1, 1'b1, 32'h106,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 1'b0, 16'd11);
        vecs[27] = mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 1'b0, 16'd11);
`endif

        // Reset values while rst is held low.
        rst  = 1'b0;
        idle = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive(idle);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_values("reset");
        #2 rst = 1'b1;

        for (int i = 0; i < 28; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Counter wrap: run accepts until the count reaches 0xFFFF, then one more.
        base_pc = vecs[27].epc;
        drive(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0));
        for (int n = 0; n < 65523; n++) begin
            @(posedge clk);
        end
        #1;
        apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                 base_pc + 32'd4 * 32'd65524, 1'b1, 1'b0, 1'b0, 16'hFFFF), "cnt_max");
        apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                 base_pc + 32'd4 * 32'd65525, 1'b1, 1'b0, 1'b0, 16'h0000), "cnt_wrap");

        // Asynchronous reset in the middle of a cycle, then a fresh boot.
        #2 rst = 1'b0;
        #1;
        chk_reset_values("async_rst");
        #2 rst = 1'b1;
        apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0), "reboot0");
        apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0), "reboot1");
        apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 1'b0, 16'd1), "reboot2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
